// File: rtl/uart_rx_byte_capture.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and a valid/ready output.
// Frame errors pulse for one cycle; FIFO drops set a sticky overflow flag.
module uart_rx_byte_capture #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic             system_clock,
    input  logic             system_reset_n,
    input  logic             uart_rtl_txd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_error,
    output logic             overflow,
    input  logic             err_clear,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic              r_sync;
    logic              r_rxs;
    logic              r_rxs_d;
    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_frame_error;
    logic              r_overflow;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_rx_data;

    logic [2:0]        w_state_d;
    logic [BAUD_W-1:0] w_baud_d;
    logic [2:0]        w_bit_idx_d;
    logic [7:0]        w_shift_d;
    logic              w_push_req;
    logic              w_frame_error_d;
    logic              w_fall;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [PTR_W-1:0]  w_rd_ptr_d;
    logic [CNT_W-1:0]  w_count_d;
    logic [7:0]        w_head;

    assign w_fall = r_rxs_d & ~r_rxs;

    always_comb begin
        w_state_d       = r_state;
        w_baud_d        = r_baud;
        w_bit_idx_d     = r_bit_idx;
        w_shift_d       = r_shift;
        w_push_req      = 1'b0;
        w_frame_error_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_baud_d  = '0;
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                if (r_baud == HALF_M1) begin
                    w_baud_d = '0;
                    if (!r_rxs) begin
                        w_state_d   = ST_DATA;
                        w_bit_idx_d = 3'd0;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_d             = '0;
                    w_shift_d[r_bit_idx] = r_rxs;
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = ST_STOP;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_baud == FULL_M1) begin
                    w_baud_d        = '0;
                    w_push_req      = r_rxs;
                    w_frame_error_d = ~r_rxs;
                    w_state_d       = r_rxs ? ST_IDLE : ST_BREAK;
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            ST_BREAK: begin
                if (r_rxs) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // A push into a full FIFO survives only when the head is popped on the same edge.
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = rx_valid & rx_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_rd_ptr_d = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_count_d  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // The next head is the byte being written when it lands in the slot the head moves to.
    always_comb begin
        w_head = r_mem[w_rd_ptr_d];
        if (w_push && (r_wr_ptr == w_rd_ptr_d)) begin
            w_head = r_shift;
        end
    end

    always_ff @(posedge system_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge system_clock) begin
        if (!system_reset_n) begin
            r_sync        <= 1'b1;
            r_rxs         <= 1'b1;
            r_rxs_d       <= 1'b1;
            r_state       <= ST_IDLE;
            r_baud        <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_frame_error <= 1'b0;
            r_overflow    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rx_data     <= 8'h00;
        end else begin
            r_sync        <= uart_rtl_txd;
            r_rxs         <= r_sync;
            r_rxs_d       <= r_rxs;
            r_state       <= w_state_d;
            r_baud        <= w_baud_d;
            r_bit_idx     <= w_bit_idx_d;
            r_shift       <= w_shift_d;
            r_frame_error <= w_frame_error_d;
            r_overflow    <= w_drop | (r_overflow & ~err_clear);
            r_wr_ptr      <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr      <= w_rd_ptr_d;
            r_count       <= w_count_d;
            if (w_count_d != '0) begin
                r_rx_data <= w_head;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = (r_count != '0);
    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;

endmodule

// File: tb/tb_uart_rx_byte_capture.sv
// Randomized and directed bench for uart_rx_byte_capture against a queue-based byte model.
module tb_uart_rx_byte_capture;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    // Stop-bit sample edge, counted from the edge after the start bit is driven:
    // two synchronizer edges, half a bit to centre, then nine whole bits.
    localparam int STOP_C = 2 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          txd;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_error;
    logic          overflow;
    logic          err_clear;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    int         obs_first_valid;
    int         obs_ferr_first;
    int         obs_ferr_cnt;
    logic [7:0] obs_data [32];
    logic       obs_v    [32];

    uart_rx_byte_capture #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .system_clock   (clk),
        .system_reset_n (rst_n),
        .uart_rtl_txd   (txd),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_error    (frame_error),
        .overflow       (overflow),
        .err_clear      (err_clear),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic clear_obs;
        obs_first_valid = -1;
        obs_ferr_first  = -1;
        obs_ferr_cnt    = 0;
    endtask

    task automatic drive_level(input int n, input logic level);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            txd      = level;
            rx_ready = 1'b0;
            @(posedge clk);
            #1;
            if (rx_valid && obs_first_valid < 0) obs_first_valid = c;
            if (frame_error) obs_ferr_cnt++;
        end
    endtask

    // Drives one 8N1 frame (optionally cut short); rx_ready is high only on cycle ready_at.
    task automatic drive_frame(input logic [7:0] data, input logic stop_bit, input int ncyc,
                               input int ready_at);
        int k;
        clear_obs();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            k = c / CPB;
            if (k == 0) txd = 1'b0;
            else if (k <= 8) txd = data[k-1];
            else txd = stop_bit;
            rx_ready = (c == ready_at);
            @(posedge clk);
            #1;
            if (rx_valid && obs_first_valid < 0) obs_first_valid = c;
            if (frame_error) begin
                if (obs_ferr_first < 0) obs_ferr_first = c;
                obs_ferr_cnt++;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_v[i]    = rx_valid;
            obs_data[i] = rx_data;
            rx_ready    = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; txd = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_error); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_level(8, 1'b1);
    endtask

    task automatic test_single_byte;
        drive_frame(8'hA5, 1'b1, 10 * CPB, -1);
        total++; if (obs_first_valid != STOP_C) begin bad++; $display("FAIL a5_latency got=%0d want=%0d", obs_first_valid, STOP_C); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", rx_data); end
        total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL a5_count got=%0d want=1", fifo_count); end
        total++; if (obs_ferr_cnt != 0) begin bad++; $display("FAIL a5_ferr got=%0d want=0", obs_ferr_cnt); end
        drain(1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL a5_empty got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_hold got=%h want=a5", rx_data); end
    endtask

    task automatic test_glitch;
        clear_obs();
        drive_level(4, 1'b0);
        drive_level(40, 1'b1);
        total++; if (obs_first_valid != -1) begin bad++; $display("FAIL glitch_push got=%0d want=-1", obs_first_valid); end
        total++; if (obs_ferr_cnt != 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", obs_ferr_cnt); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL glitch_count got=%0d want=0", fifo_count); end
        drive_frame(8'h96, 1'b1, 10 * CPB, -1);
        total++; if (obs_first_valid != STOP_C) begin bad++; $display("FAIL glitch_rearm got=%0d want=%0d", obs_first_valid, STOP_C); end
        total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL glitch_data got=%h want=96", rx_data); end
        drain(1);
    endtask

    task automatic test_frame_error;
        drive_frame(8'h3C, 1'b0, 10 * CPB, -1);
        total++; if (obs_ferr_cnt != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", obs_ferr_cnt); end
        total++; if (obs_ferr_first != STOP_C) begin bad++; $display("FAIL ferr_time got=%0d want=%0d", obs_ferr_first, STOP_C); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ferr_count got=%0d want=0", fifo_count); end
        clear_obs();
        drive_level(40, 1'b0);
        drive_level(16, 1'b1);
        total++; if (obs_first_valid != -1) begin bad++; $display("FAIL break_push got=%0d want=-1", obs_first_valid); end
        total++; if (obs_ferr_cnt != 0) begin bad++; $display("FAIL break_ferr got=%0d want=0", obs_ferr_cnt); end
        drive_frame(8'h11, 1'b1, 10 * CPB, -1);
        total++; if (obs_first_valid != STOP_C) begin bad++; $display("FAIL after_break_lat got=%0d want=%0d", obs_first_valid, STOP_C); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL after_break_data got=%h want=11", rx_data); end
        drain(1);
    endtask

    task automatic test_overflow;
        for (int b = 0; b < 17; b++) drive_frame(8'(b), 1'b1, 10 * CPB, -1);
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        drain(16);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_v[i] !== 1'b1 || obs_data[i] !== 8'(i)) begin
                bad++; $display("FAIL ovf_drain[%0d] got=%b/%h want=1/%h", i, obs_v[i], obs_data[i], 8'(i));
            end
        end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_drained got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_full_pop;
        for (int b = 0; b < 16; b++) drive_frame(8'h20 + 8'(b), 1'b1, 10 * CPB, -1);
        drive_frame(8'h30, 1'b1, 10 * CPB, STOP_C);
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL fullpop_count got=%0d want=16", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b want=0", overflow); end
        drain(16);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_v[i] !== 1'b1 || obs_data[i] !== 8'h21 + 8'(i)) begin
                bad++; $display("FAIL fullpop_drain[%0d] got=%b/%h want=1/%h", i, obs_v[i], obs_data[i], 8'h21 + 8'(i));
            end
        end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL fullpop_drained got=%0d want=0", fifo_count); end
    endtask

    task automatic test_reset_mid;
        drive_frame(8'h77, 1'b1, 10 * CPB, -1);
        total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL rmid_pre got=%0d want=1", fifo_count); end
        drive_frame(8'hFF, 1'b1, 5 * CPB, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", rx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b0 || frame_error !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b want=00", overflow, frame_error); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        drive_level(5 * CPB, 1'b1);
        total++; if (obs_first_valid != -1) begin bad++; $display("FAIL rmid_partial got=%0d want=-1", obs_first_valid); end
        drive_frame(8'h5A, 1'b1, 10 * CPB, -1);
        total++; if (obs_first_valid != STOP_C) begin bad++; $display("FAIL rmid_lat got=%0d want=%0d", obs_first_valid, STOP_C); end
        total++; if (rx_data !== 8'h5A || fifo_count !== 5'd1) begin bad++; $display("FAIL rmid_5a got=%h/%0d want=5a/1", rx_data, fifo_count); end
        drain(1);
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        logic [7:0] b;
        logic       popping;
        int         gap;
        int         p;
        int         n;
        for (int f = 0; f < 12; f++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 20);
            for (int c = 0; c < gap + 10 * CPB; c++) begin
                p = c - gap;
                @(negedge clk);
                if (p < 0) txd = 1'b1;
                else if (p < CPB) txd = 1'b0;
                else if (p < 9 * CPB) txd = b[p/CPB-1];
                else txd = 1'b1;
                rx_ready = 1'($urandom_range(0, 1));
                popping  = rx_valid && rx_ready;
                if (popping) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++; $display("FAIL rand_pop got=%h want=no_valid", rx_data);
                    end else if (rx_data !== q[0]) begin
                        bad++; $display("FAIL rand_pop got=%h want=%h", rx_data, q[0]);
                    end
                end
                @(posedge clk);
                #1;
                if (popping && q.size() > 0) void'(q.pop_front());
                if (p == STOP_C) q.push_back(b);
                total++;
                if (fifo_count !== CW'(q.size())) begin
                    bad++; $display("FAIL rand_count got=%0d want=%0d", fifo_count, q.size());
                end
            end
        end
        rx_ready = 1'b0;
        n = q.size();
        drain(n);
        for (int i = 0; i < n; i++) begin
            total++;
            if (obs_v[i] !== 1'b1 || obs_data[i] !== q[i]) begin
                bad++; $display("FAIL rand_drain[%0d] got=%b/%h want=1/%h", i, obs_v[i], obs_data[i], q[i]);
            end
        end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rand_drained got=%0d want=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_capture.md
Name: uart_rx_byte_capture

Overview:
- Synthesizable 8N1 UART receiver that consumes the SoC serial output (uart_rtl_txd of the MicroBlaze wrapper) and turns it into a byte stream with a valid/ready interface.
- Sits directly downstream of the SoC UART. It buffers the HIGHT ciphertext/status bytes in a small FIFO so the bench scoreboard (or an on-board checker) can check them without bit-level timing.

Parameters:
- CLKS_PER_BIT, 868, system_clock cycles per UART bit (100 MHz / 115200); legal range 8 or more.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, 2 or more.
- CNT_W, 5, width of fifo_count; must equal log2(FIFO_DEPTH)+1.

Ports:
- system_clock  input  1  single system clock; all logic on the rising edge.
- system_reset_n  input  1  synchronous, active-low reset.
- uart_rtl_txd  input  1  asynchronous serial line from the SoC; idle high.
- rx_data  output  8  byte at the FIFO head.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts rx_data; a pop occurs when rx_valid and rx_ready are both high.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- err_clear  input  1  clears overflow.
- fifo_count  output  CNT_W  number of bytes held.

Behaviour:
- Reset (system_reset_n low at a clock edge):
  - Synchronizer flops are set to 1.
  - FSM goes to IDLE; bit counter and baud counter go to 0.
  - FIFO is emptied.
  - rx_valid=0, rx_data=0, frame_error=0, overflow=0, fifo_count=0.
  - A reset in the middle of a frame discards the partial byte. After reset the FSM re-arms only on a new falling edge seen in IDLE.
- Input sync: two-flop synchronizer on uart_rtl_txd. All decisions use the second flop (rxs). Edge detection adds one extra flop of rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a falling edge of rxs loads baud_cnt=0 and moves to START.
  - START: when baud_cnt reaches CLKS_PER_BIT/2-1 (integer divide), sample rxs.
    - rxs=0: reset baud_cnt and move to DATA with bit_idx=0.
    - rxs=1: treat as a glitch and return to IDLE. Nothing is pushed and no flag is raised.
  - DATA: each time baud_cnt reaches CLKS_PER_BIT-1, sample rxs into shift[bit_idx] (LSB first) and reset baud_cnt.
    - After bit_idx=7, move to STOP.
  - STOP: sample when baud_cnt reaches CLKS_PER_BIT-1.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: pulse frame_error for one cycle, discard the byte and go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A line held low never produces bytes.
- Push timing: the byte is written on the stop-sample edge. rx_valid rises and fifo_count increments on the next cycle (1-cycle latency from the stop sample).
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - rx_data is the head entry, registered and first-word-fall-through. When empty, rx_data holds its last value.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and fifo_count is unchanged.
  - Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop when not full: both take effect and fifo_count is unchanged.
- Pop when empty is impossible, because rx_valid=0.
- overflow stays set until err_clear=1. If err_clear and a new drop occur in the same cycle, overflow stays 1 (set wins).
- Back-to-back frames: a new start bit may begin the cycle after the STOP sample. No idle time is required.
- baud_cnt width is clog2(CLKS_PER_BIT). Counters never exceed CLKS_PER_BIT-1.

Test Plan:
- CLKS_PER_BIT=16: send 0xA5 framed as start=0, bits 1,0,1,0,0,1,0,1, stop=1 -> rx_valid=1 and rx_data=0xA5 one cycle after the stop sample; fifo_count=1; frame_error=0.
- Low glitch of 4 cycles on the idle line -> no push; fifo_count=0; frame_error=0; FSM back in IDLE.
- Frame 0x3C with stop bit driven 0 -> single-cycle frame_error pulse; fifo_count=0. Line held low for 40 cycles, then high, then 0x11 sent -> rx_data=0x11.
- rx_ready=0, send 17 bytes 0x00..0x10 back-to-back -> fifo_count=16, overflow=1. Draining returns 0x00..0x0F in order; err_clear pulse -> overflow=0.
- FIFO full, rx_ready=1 during the 17th byte's stop sample -> byte 0x10 accepted, fifo_count stays 16, overflow=0.
- system_reset_n=0 for one cycle after data bit 3 of 0xFF, then send 0x5A -> only 0x5A is received; all outputs show reset values immediately after the reset edge.
